// File: rtl/raw_hazard_scoreboard.sv
// rtl/raw_hazard_scoreboard.sv - RAW hazard unit: load-use stall and registered forwarding selects
module raw_hazard_scoreboard #(
    parameter int NREG       = 4,
    parameter int RW         = 2,
    parameter int DEPTH      = 3,
    parameter int LOAD_STAGE = 2,
    parameter int CNT_W      = 16,
    parameter int SELW       = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic             id_wr,
    input  logic             id_load,
    input  logic [RW-1:0]    id_rd,
    input  logic [RW-1:0]    id_ra,
    input  logic [RW-1:0]    id_rb,
    input  logic             id_use_a,
    input  logic             id_use_b,
    input  logic             flush,
    input  logic             hold,
    output logic             stall,
    output logic             ex_valid,
    output logic [SELW-1:0]  fwd_a_sel,
    output logic [SELW-1:0]  fwd_b_sel,
    output logic [CNT_W-1:0] stall_count
);

    // Destination indices at or above NREG name no architectural register.
    localparam logic [RW:0] NREG_L = (RW + 1)'(NREG);

    // Shadow of in-flight producers: entry 0 = EX ... entry DEPTH-1 = WB.
    logic [DEPTH-1:0] vld_q, vld_d;
    logic [DEPTH-1:0] ld_q, ld_d;
    logic [RW-1:0]    rd_q [DEPTH];
    logic [RW-1:0]    rd_d [DEPTH];

    logic             ex_valid_q, ex_valid_d;
    logic [SELW-1:0]  sel_a_q, sel_a_d;
    logic [SELW-1:0]  sel_b_q, sel_b_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [SELW-1:0]  match_a, match_b;
    logic             haz_a, haz_b, hazard;

    // Youngest-producer match per source; scanning from WB down lets the lowest k win.
    always_comb begin
        match_a = '0;
        match_b = '0;
        haz_a   = 1'b0;
        haz_b   = 1'b0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            if (vld_q[k] && rd_q[k] == id_ra) begin
                match_a = SELW'(k + 1);
                haz_a   = ld_q[k] && (k + 1 < LOAD_STAGE);
            end
            if (vld_q[k] && rd_q[k] == id_rb) begin
                match_b = SELW'(k + 1);
                haz_b   = ld_q[k] && (k + 1 < LOAD_STAGE);
            end
        end
        if (!id_use_a) begin
            match_a = '0;
            haz_a   = 1'b0;
        end
        if (!id_use_b) begin
            match_b = '0;
            haz_b   = 1'b0;
        end
        hazard = id_valid && (haz_a || haz_b);
    end

    assign stall = hold | (hazard & ~flush);

    // Next state: hold freezes everything, otherwise shift and insert instruction or bubble.
    always_comb begin
        vld_d      = vld_q;
        ld_d       = ld_q;
        rd_d       = rd_q;
        ex_valid_d = ex_valid_q;
        sel_a_d    = sel_a_q;
        sel_b_d    = sel_b_q;
        cnt_d      = cnt_q;
        if (!hold) begin
            for (int k = DEPTH - 1; k > 0; k--) begin
                vld_d[k] = vld_q[k-1];
                ld_d[k]  = ld_q[k-1];
                rd_d[k]  = rd_q[k-1];
            end
            vld_d[0]   = 1'b0;
            ld_d[0]    = 1'b0;
            rd_d[0]    = id_rd;
            ex_valid_d = 1'b0;
            sel_a_d    = '0;
            sel_b_d    = '0;
            if (!flush) begin
                if (hazard) begin
                    if (cnt_q != '1) begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end else begin
                    vld_d[0]   = id_valid && id_wr && ({1'b0, id_rd} < NREG_L);
                    ld_d[0]    = id_load;
                    ex_valid_d = id_valid;
                    sel_a_d    = match_a;
                    sel_b_d    = match_b;
                end
            end
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q      <= '0;
            ld_q       <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                rd_q[k] <= '0;
            end
            ex_valid_q <= 1'b0;
            sel_a_q    <= '0;
            sel_b_q    <= '0;
            cnt_q      <= '0;
        end else begin
            vld_q      <= vld_d;
            ld_q       <= ld_d;
            rd_q       <= rd_d;
            ex_valid_q <= ex_valid_d;
            sel_a_q    <= sel_a_d;
            sel_b_q    <= sel_b_d;
            cnt_q      <= cnt_d;
        end
    end

    assign ex_valid    = ex_valid_q;
    assign fwd_a_sel   = sel_a_q;
    assign fwd_b_sel   = sel_b_q;
    assign stall_count = cnt_q;

endmodule

// File: tb/tb_raw_hazard_scoreboard.sv
// tb/tb_raw_hazard_scoreboard.sv - scoreboard bench for raw_hazard_scoreboard
module tb_raw_hazard_scoreboard;

    localparam int NREG       = 4;
    localparam int RW         = 2;
    localparam int DEPTH      = 3;
    localparam int LOAD_STAGE = 2;
    localparam int CNT_W      = 4;
    localparam int SELW       = $clog2(DEPTH + 1);

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst, id_valid, id_wr, id_load, id_use_a, id_use_b, flush, hold;
    logic [RW-1:0]    id_rd, id_ra, id_rb;
    logic             stall, ex_valid;
    logic [SELW-1:0]  fwd_a_sel, fwd_b_sel;
    logic [CNT_W-1:0] stall_count;

    raw_hazard_scoreboard #(
        .NREG(NREG), .RW(RW), .DEPTH(DEPTH), .LOAD_STAGE(LOAD_STAGE),
        .CNT_W(CNT_W), .SELW(SELW)
    ) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_wr(id_wr), .id_load(id_load),
        .id_rd(id_rd), .id_ra(id_ra), .id_rb(id_rb), .id_use_a(id_use_a),
        .id_use_b(id_use_b), .flush(flush), .hold(hold), .stall(stall),
        .ex_valid(ex_valid), .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
        .stall_count(stall_count)
    );

    typedef struct {
        bit chk_stall;
        bit st;
        bit exv;
        int sa;
        int sb;
        int cnt;
    } exp_t;
    exp_t exp_q[$];

    // Reference model: every accepted writer with the advance count at which it entered EX.
    typedef struct {
        int rd;
        bit load;
        int ins;
    } prod_t;
    prod_t prods[$];
    int adv   = 0;
    bit m_ex  = 0;
    int m_sa  = 0;
    int m_sb  = 0;
    int m_cnt = 0;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, expv, $time);
        end
    endtask

    function automatic void find(input int s, output bit found, output int k, output bit ld);
        found = 0;
        k     = 0;
        ld    = 0;
        foreach (prods[i]) begin
            int age;
            age = adv - prods[i].ins - 1;
            if (age < DEPTH && prods[i].rd == s && (!found || age < k)) begin
                found = 1;
                k     = age;
                ld    = prods[i].load;
            end
        end
    endfunction

    // One decode cycle: drive inputs, predict stall and post-edge outputs, advance the model.
    task automatic step(input bit v, input bit wr, input bit ld, input int rd, input int ra,
                        input int rb, input bit ua, input bit ub, input bit fl, input bit hd,
                        input bit rs, input bit chk_st, output bit st);
        bit fa, fb, la, lb, ha, hb, hazard;
        int ka, kb;
        exp_t e;
        @(negedge clk);
        id_valid = v;  id_wr = wr;  id_load = ld;
        id_rd = RW'(rd);  id_ra = RW'(ra);  id_rb = RW'(rb);
        id_use_a = ua;  id_use_b = ub;  flush = fl;  hold = hd;  rst = rs;
        #1;
        find(ra, fa, ka, la);
        find(rb, fb, kb, lb);
        ha = ua && fa && la && (ka + 1 < LOAD_STAGE);
        hb = ub && fb && lb && (kb + 1 < LOAD_STAGE);
        hazard = v && (ha || hb);
        st = hd || (hazard && !fl);
        if (rs) begin
            prods.delete();
            m_ex = 0;  m_sa = 0;  m_sb = 0;  m_cnt = 0;
        end else if (!hd) begin
            if (fl) begin
                m_ex = 0;  m_sa = 0;  m_sb = 0;
            end else if (hazard) begin
                m_ex = 0;  m_sa = 0;  m_sb = 0;
                if (m_cnt < (1 << CNT_W) - 1) m_cnt++;
            end else begin
                m_ex = v;
                m_sa = (ua && fa) ? ka + 1 : 0;
                m_sb = (ub && fb) ? kb + 1 : 0;
                if (v && wr) prods.push_back('{rd, ld, adv});
            end
            adv++;
            while (prods.size() > 0 && adv - prods[0].ins - 1 >= DEPTH) void'(prods.pop_front());
        end
        e = '{chk_st, st, m_ex, m_sa, m_sb, m_cnt};
        exp_q.push_back(e);
    endtask

    task automatic nop();
        bit st;
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, st);
    endtask

    // Decode keeps presenting the instruction while the model says it is stalled.
    task automatic issue(input bit wr, input bit ld, input int rd, input int ra, input int rb,
                         input bit ua, input bit ub);
        bit st;
        int n;
        n = 0;
        do begin
            step(1, wr, ld, rd, ra, rb, ua, ub, 0, 0, 0, 1, st);
            n++;
        end while (st && n < 10);
        chk("issue_bound", 32'(st), 32'(0));
    endtask

    // Monitor: sample stall mid-cycle, compare registered outputs just after the edge.
    initial begin
        exp_t e;
        logic st_s;
        forever begin
            @(negedge clk);
            #2;
            st_s = stall;
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                if (e.chk_stall) chk("stall", 32'(st_s), 32'(e.st));
                chk("ex_valid", 32'(ex_valid), 32'(e.exv));
                chk("fwd_a_sel", 32'(fwd_a_sel), 32'(e.sa));
                chk("fwd_b_sel", 32'(fwd_b_sel), 32'(e.sb));
                chk("stall_count", 32'(stall_count), 32'(e.cnt));
            end
        end
    end

    initial begin
        bit st;
        rst = 1;  id_valid = 0;  id_wr = 0;  id_load = 0;  id_rd = 0;  id_ra = 0;  id_rb = 0;
        id_use_a = 0;  id_use_b = 0;  flush = 0;  hold = 0;

        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, st);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, st);
        nop();

        // LDM R1; LDM R0; STD R0; LDD R2; ADD R1,R2
        issue(1, 0, 1, 0, 0, 0, 0);
        issue(1, 0, 0, 0, 0, 0, 0);
        issue(0, 0, 0, 0, 0, 1, 0);
        issue(1, 1, 2, 0, 0, 0, 0);
        issue(1, 0, 1, 1, 2, 1, 1);
        repeat (3) nop();

        // ADD R1,R2 then SUB R3,R1
        issue(1, 0, 1, 1, 2, 1, 1);
        issue(1, 0, 3, 3, 1, 1, 1);
        repeat (3) nop();

        // Two writers of R2, then a consumer
        issue(1, 0, 2, 0, 0, 0, 0);
        issue(1, 0, 2, 2, 1, 1, 1);
        issue(1, 0, 3, 2, 2, 1, 1);
        repeat (3) nop();

        // Load-use under hold for three cycles, then flush on release
        issue(1, 1, 1, 0, 0, 0, 0);
        repeat (3) step(1, 1, 0, 2, 1, 0, 1, 0, 0, 1, 0, 1, st);
        step(1, 1, 0, 2, 1, 0, 1, 0, 1, 0, 0, 1, st);
        repeat (3) nop();

        // Saturate the stall counter
        repeat (20) begin
            issue(1, 1, 3, 0, 0, 0, 0);
            issue(1, 0, 0, 0, 3, 0, 1);
        end
        repeat (3) nop();

        // Reset in the middle of a stall
        issue(1, 1, 1, 0, 0, 0, 0);
        step(1, 1, 0, 2, 1, 1, 1, 1, 0, 0, 1, 1, st);
        step(1, 1, 0, 2, 1, 1, 1, 1, 0, 0, 0, 1, st);
        repeat (3) nop();

        // Randomized traffic
        repeat (3000) begin
            step($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                 $urandom_range(0, NREG - 1), $urandom_range(0, NREG - 1), $urandom_range(0, NREG - 1),
                 $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                 $urandom_range(0, 15) == 0, $urandom_range(0, 7) == 0,
                 $urandom_range(0, 199) == 0, 1, st);
        end
        repeat (3) nop();

        repeat (3) @(posedge clk);
        #5;
        chk("scoreboard_drained", 32'(exp_q.size()), 32'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
